// File: rtl/multi_player_match_game.sv
// multi_player_match_game: N-player timed sequence-matching game controller.
// Password unlock, LFSR targets, timed guess capture, scoring and winners.
module multi_player_match_game #(
   parameter int NUM_PLAYERS = 2,
   parameter int SEQ_W = 4,
   parameter int ROUNDS = 8,
   parameter int PAS_LEN = 6,
   parameter logic [PAS_LEN-1:0] PAS_VAL = 6'b111111,
   parameter int TIMEOUT = 50,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int SCORE_W = $clog2(ROUNDS + 1)
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Start,
   input  logic Stop,
   input  logic Pas,
   input  logic AcsPas,
   input  logic AcsRNG,
   input  logic [NUM_PLAYERS-1:0] AcsP,
   input  logic [NUM_PLAYERS*SEQ_W-1:0] Guess,
   output logic [SEQ_W-1:0] Target,
   output logic [NUM_PLAYERS*SCORE_W-1:0] Score,
   output logic [SCORE_W-1:0] Round,
   output logic [NUM_PLAYERS-1:0] Win,
   output logic Tie,
   output logic BadPas,
   output logic [2:0] State
);

   localparam int CNT_W = $clog2(PAS_LEN + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int PCNT_W = $clog2(NUM_PLAYERS + 1);

   typedef enum logic [2:0] {
      stIdle = 3'd0,
      stUnlock = 3'd1,
      stWaitRng = 3'd2,
      stGuess = 3'd3,
      stScore = 3'd4,
      stDone = 3'd5
   } stateT;

   stateT state, stateNext;

   logic [15:0] lfsr, lfsrNext;
   logic pasQ, rngQ, startQ;
   logic [NUM_PLAYERS-1:0] pQ;
   logic pasEdge, rngEdge, startEdge;
   logic [NUM_PLAYERS-1:0] pEdge;

   logic [CNT_W-1:0] pasCnt;
   logic [PAS_LEN-1:0] pasShift, pasShiftNext;
   logic pasFull, pasOk;

   logic [TMR_W-1:0] timer;
   logic timerLast;
   logic [NUM_PLAYERS-1:0] captured, capNext;
   logic allCap;
   logic [SEQ_W-1:0] guessR [NUM_PLAYERS];

   logic [SCORE_W-1:0] scoreR [NUM_PLAYERS];
   logic [SCORE_W-1:0] scoreNext [NUM_PLAYERS];
   logic [SCORE_W-1:0] maxScore;
   logic [NUM_PLAYERS-1:0] winNext;
   logic [PCNT_W-1:0] winCnt;
   logic tieNext;
   logic lastRound;

   logic clearGame, doPas, doLoad, inGuess, doScore;

   // Galois LFSR, taps 16,14,13,11
   always_comb begin
      lfsrNext = {1'b0, lfsr[15:1]};
      if (lfsr[0]) begin
         lfsrNext = lfsrNext ^ 16'hB400;
      end
   end

   always_comb begin
      pasEdge = AcsPas & ~pasQ;
      rngEdge = AcsRNG & ~rngQ;
      startEdge = Start & ~startQ;
      pEdge = AcsP & ~pQ;
      pasShiftNext = PAS_LEN'({pasShift, Pas});
      pasFull = pasEdge && (pasCnt == CNT_W'(PAS_LEN - 1));
      pasOk = (pasShiftNext == PAS_VAL);
      capNext = captured | pEdge;
      allCap = &capNext;
      timerLast = (timer == TMR_W'(1));
      lastRound = (Round == SCORE_W'(ROUNDS - 1));
   end

   // Winner flags come from the post-round scores
   always_comb begin
      maxScore = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         scoreNext[i] = scoreR[i];
         if (captured[i] && guessR[i] == Target &&
             scoreR[i] != SCORE_W'(ROUNDS)) begin
            scoreNext[i] = scoreR[i] + SCORE_W'(1);
         end
         if (scoreNext[i] > maxScore) begin
            maxScore = scoreNext[i];
         end
      end
      winCnt = '0;
      winNext = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         winNext[i] = (scoreNext[i] == maxScore);
         winCnt = winCnt + PCNT_W'(winNext[i]);
      end
      tieNext = (winCnt > PCNT_W'(1));
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         stIdle: begin
            if (Start) stateNext = stUnlock;
         end
         stUnlock: begin
            if (pasFull) stateNext = pasOk ? stWaitRng : stIdle;
         end
         stWaitRng: begin
            if (rngEdge) stateNext = stGuess;
         end
         stGuess: begin
            if (allCap || timerLast) stateNext = stScore;
         end
         stScore: begin
            stateNext = lastRound ? stDone : stWaitRng;
         end
         stDone: begin
            if (startEdge) stateNext = stUnlock;
         end
         default: stateNext = stIdle;
      endcase
      if (Stop) stateNext = stIdle;
   end

   always_comb begin
      clearGame = !Stop && ((state == stIdle && Start) ||
                            (state == stDone && startEdge));
      doPas = !Stop && state == stUnlock && pasEdge;
      doLoad = !Stop && state == stWaitRng && rngEdge;
      inGuess = !Stop && state == stGuess;
      doScore = !Stop && state == stScore;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= stIdle;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         lfsr <= LFSR_SEED;
         pasQ <= 1'b0;
         rngQ <= 1'b0;
         startQ <= 1'b0;
         pQ <= '0;
         pasCnt <= '0;
         pasShift <= '0;
         timer <= '0;
         captured <= '0;
         Target <= '0;
         Round <= '0;
         Win <= '0;
         Tie <= 1'b0;
         BadPas <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            guessR[i] <= '0;
            scoreR[i] <= '0;
         end
      end else begin
         lfsr <= lfsrNext;
         pasQ <= AcsPas;
         rngQ <= AcsRNG;
         startQ <= Start;
         pQ <= AcsP;
         BadPas <= 1'b0;
         if (clearGame) begin
            pasCnt <= '0;
            pasShift <= '0;
            Round <= '0;
            Win <= '0;
            Tie <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               scoreR[i] <= '0;
            end
         end
         if (doPas) begin
            pasShift <= pasShiftNext;
            pasCnt <= pasCnt + CNT_W'(1);
            if (pasFull && !pasOk) BadPas <= 1'b1;
         end
         if (doLoad) begin
            Target <= lfsr[SEQ_W-1:0];
            captured <= '0;
            timer <= TMR_W'(TIMEOUT);
         end
         if (inGuess) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               if (pEdge[i] && !captured[i]) begin
                  guessR[i] <= Guess[i*SEQ_W +: SEQ_W];
               end
            end
            captured <= capNext;
            timer <= timer - TMR_W'(1);
         end
         if (doScore) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               scoreR[i] <= scoreNext[i];
            end
            Round <= Round + SCORE_W'(1);
            Win <= winNext;
            Tie <= tieNext;
         end
      end
   end

   always_comb begin
      Score = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         Score[i*SCORE_W +: SCORE_W] = scoreR[i];
      end
      State = state;
   end

endmodule

// File: tb/tb_multi_player_match_game.sv
// tb_multi_player_match_game: directed vectors plus multi-cycle game
// sequences for the 3-player, 2-round configuration.
module tb_multi_player_match_game;

   localparam int NP = 3;
   localparam int SW = 4;
   localparam int SCW = 2;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   logic Start = 1'b0;
   logic Stop = 1'b0;
   logic Pas = 1'b0;
   logic AcsPas = 1'b0;
   logic AcsRNG = 1'b0;
   logic [NP-1:0] AcsP = '0;
   logic [NP*SW-1:0] Guess = '0;
   logic [SW-1:0] Target;
   logic [NP*SCW-1:0] Score;
   logic [SCW-1:0] Round;
   logic [NP-1:0] Win;
   logic Tie;
   logic BadPas;
   logic [2:0] State;

   logic [15:0] refLfsr;
   logic [SW-1:0] expT;
   int nChk = 0;
   int nFail = 0;

   typedef struct {
      logic start;
      logic stop;
      logic pas;
      logic acs;
      logic [2:0] expState;
      logic expBad;
   } vecT;

   vecT vecs[$];

   multi_player_match_game #(
      .NUM_PLAYERS(NP),
      .SEQ_W(SW),
      .ROUNDS(2),
      .PAS_LEN(6),
      .PAS_VAL(6'b111111),
      .TIMEOUT(50),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .Start(Start),
      .Stop(Stop),
      .Pas(Pas),
      .AcsPas(AcsPas),
      .AcsRNG(AcsRNG),
      .AcsP(AcsP),
      .Guess(Guess),
      .Target(Target),
      .Score(Score),
      .Round(Round),
      .Win(Win),
      .Tie(Tie),
      .BadPas(BadPas),
      .State(State)
   );

   always #5 Clk = ~Clk;

   // Reference Galois LFSR, bit-level form of x^16+x^14+x^13+x^11+1
   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         refLfsr <= 16'hACE1;
      end else begin
         refLfsr <= {refLfsr[0], refLfsr[15],
                     refLfsr[14] ^ refLfsr[0],
                     refLfsr[13] ^ refLfsr[0],
                     refLfsr[12],
                     refLfsr[11] ^ refLfsr[0],
                     refLfsr[10:1]};
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unlock(input string tag);
      for (int i = 0; i < 6; i++) begin
         Pas = 1'b1;
         AcsPas = 1'b1;
         step();
         AcsPas = 1'b0;
         step();
      end
      Pas = 1'b0;
      chk({tag, " unlock state"}, 32'(State), 32'd2);
   endtask

   task automatic rng(input string tag);
      AcsRNG = 1'b1;
      expT = refLfsr[SW-1:0];
      step();
      AcsRNG = 1'b0;
      chk({tag, " rng state"}, 32'(State), 32'd3);
      chk({tag, " target"}, 32'(Target), 32'(expT));
   endtask

   initial begin
      // start stop pas acs -> state badPas
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0});
      for (int i = 0; i < 5; i++) begin
         vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0});
         vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0});
      end
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0});

      step();
      chk("reset state", 32'(State), 32'd0);
      chk("reset target", 32'(Target), 32'd0);
      chk("reset score", 32'(Score), 32'd0);
      chk("reset round", 32'(Round), 32'd0);
      chk("reset win", 32'(Win), 32'd0);
      chk("reset tie", 32'(Tie), 32'd0);
      chk("reset badpas", 32'(BadPas), 32'd0);
      step();
      Rst = 1'b1;
      step();

      foreach (vecs[i]) begin
         Start = vecs[i].start;
         Stop = vecs[i].stop;
         Pas = vecs[i].pas;
         AcsPas = vecs[i].acs;
         step();
         chk($sformatf("vec%0d state", i), 32'(State),
             32'(vecs[i].expState));
         chk($sformatf("vec%0d badpas", i), 32'(BadPas),
             32'(vecs[i].expBad));
      end
      Start = 1'b0;
      Pas = 1'b0;
      AcsPas = 1'b0;

      // Game 1, round 1: all strobe, only player 0 right
      rng("g1r1");
      Guess = {~expT, ~expT, expT};
      AcsP = 3'b111;
      step();
      chk("g1r1 all captured", 32'(State), 32'd4);
      AcsP = 3'b000;
      step();
      chk("g1r1 state", 32'(State), 32'd2);
      chk("g1r1 score", 32'(Score), 32'b00_00_01);
      chk("g1r1 round", 32'(Round), 32'd1);

      // Game 1, round 2: player 2 only, held strobe, late re-strobe
      rng("g1r2");
      Guess = {expT, ~expT, ~expT};
      AcsP = 3'b100;
      for (int k = 1; k <= 49; k++) begin
         if (k == 10) AcsP = 3'b000;
         if (k == 12) begin
            AcsP = 3'b100;
            Guess[2*SW +: SW] = ~expT;
         end
         step();
      end
      chk("g1r2 still guess", 32'(State), 32'd3);
      step();
      chk("g1r2 timeout", 32'(State), 32'd4);
      step();
      AcsP = 3'b000;
      chk("g1 done state", 32'(State), 32'd5);
      chk("g1 score", 32'(Score), 32'b01_00_01);
      chk("g1 round", 32'(Round), 32'd2);
      chk("g1 win", 32'(Win), 32'b101);
      chk("g1 tie", 32'(Tie), 32'd1);

      Start = 1'b1;
      step();
      Start = 1'b0;
      chk("restart state", 32'(State), 32'd1);
      chk("restart score", 32'(Score), 32'd0);
      chk("restart round", 32'(Round), 32'd0);
      chk("restart win", 32'(Win), 32'd0);
      chk("restart tie", 32'(Tie), 32'd0);
      unlock("g2");

      // Game 2, round 1: player 1 strobes on the expiry cycle
      rng("g2r1");
      Guess = {~expT, expT, ~expT};
      repeat (49) step();
      AcsP = 3'b010;
      step();
      chk("g2r1 expiry", 32'(State), 32'd4);
      AcsP = 3'b000;
      step();
      chk("g2r1 state", 32'(State), 32'd2);
      chk("g2r1 score", 32'(Score), 32'b00_01_00);
      chk("g2r1 round", 32'(Round), 32'd1);

      // Game 2, round 2: Stop with Start held during GUESS
      rng("g2r2");
      repeat (3) step();
      Stop = 1'b1;
      Start = 1'b1;
      step();
      chk("stop state", 32'(State), 32'd0);
      chk("stop score held", 32'(Score), 32'b00_01_00);
      chk("stop round held", 32'(Round), 32'd1);
      Stop = 1'b0;
      step();
      Start = 1'b0;
      chk("start after stop", 32'(State), 32'd1);
      chk("start clr score", 32'(Score), 32'd0);
      chk("start clr round", 32'(Round), 32'd0);

      // Game 3: score once, then async reset mid-GUESS
      unlock("g3");
      rng("g3r1");
      Guess = {~expT, ~expT, expT};
      AcsP = 3'b111;
      step();
      AcsP = 3'b000;
      step();
      chk("g3r1 score", 32'(Score), 32'b00_00_01);
      chk("g3r1 win", 32'(Win), 32'b001);
      rng("g3r2");
      step();
      #2;
      Rst = 1'b0;
      #1;
      chk("async state", 32'(State), 32'd0);
      chk("async target", 32'(Target), 32'd0);
      chk("async score", 32'(Score), 32'd0);
      chk("async round", 32'(Round), 32'd0);
      chk("async win", 32'(Win), 32'd0);
      chk("async tie", 32'(Tie), 32'd0);
      chk("async badpas", 32'(BadPas), 32'd0);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChk, nFail);
      $finish;
   end

endmodule
